mnist_synth_top: RTL and testbench
==================================

// Module: mnist_synth_top
// PURPOSE
//   Self-contained MNIST inference top. It holds three test images and all MLP weights in on-chip ROM (BRAM).
//   On start, it runs a 784->N_HID->10 integer MLP on the selected image and reports the argmax digit.
//   It sits directly under the board wrapper. Buttons/switches drive start/img_sel; LEDs/console show digit/done/valid.
// PARAMETERS
//   N_IN    784   pixels per image (28x28, 8-bit unsigned, row-major)
//   N_HID   32    hidden neurons
//   N_OUT   10    output classes
//   SHIFT   7     arithmetic right shift applied to layer-1 sums before ReLU/saturation
//   IMG0/1/2_FILE "test_img0.mem"/"test_img1.mem"/"test_img2.mem"  hex image init files
//   W1/B1/W2/B2_FILE "w1.mem"/"b1.mem"/"w2.mem"/"b2.mem"  weight files: int8 weights, int32 biases
// PORTS
//   clk      in   1  system clock (100 MHz target)
//   rst      in   1  asynchronous reset, active-low
//   start    in   1  request inference; sampled on clk rising edge
//   img_sel  in   2  image select: 0,1,2 valid; 3 invalid
//   digit    out  4  predicted class 0..9, held after completion
//   done     out  1  result ready (level)
//   valid    out  1  combinational: 1 when img_sel < 3
// BEHAVIOUR
// - Reset (rst=0, async):
//     * FSM -> IDLE; digit=0; done=0; all accumulators cleared.
//     * valid still follows img_sel.
// - exp_label (internal 4-bit, probe-visible at top):
//     * Expected label of the selected image: 0->6, 1->2, 2->3, 3->0.
// - Required hierarchy for debug probes:
//     * Datapath instance named accel.
//     * accel contains FSM instance fsm with register state.
//     * accel also holds signed 32-bit array l2_acc[0:9].
// - FSM states: IDLE, L1_MAC, L1_WB, L2_MAC, L2_WB, ARGMAX, DONE.
//     * IDLE: start=1 AND valid=1 at a clock edge:
//         - latch img_sel
//         - clear done
//         - go to L1_MAC
//       start with valid=0 is ignored; stay IDLE, done stays 0.
//     * L1_MAC: acc = b1[j] + sum_i pix[i]*w1[j][i].
//         - One MAC per cycle.
//         - Synchronous ROM reads with 1-cycle latency; the address pipeline absorbs it.
//     * L1_WB:
//         - h[j] = clamp(acc>>>SHIFT, 0, 127)
//         - j++
//         - j==N_HID-1 -> L2_MAC, else L1_MAC
//     * L2_MAC / L2_WB:
//         - l2_acc[k] = b2[k] + sum_j h[j]*w2[k][j]; no activation
//         - k==9 -> ARGMAX
//     * ARGMAX:
//         - Sequential compare over l2_acc, signed.
//         - Ties resolve to the lowest index.
//         - digit updated on exit.
//     * DONE:
//         - done=1; digit stable.
//         - Stays until a new accepted start (-> L1_MAC, done drops the next cycle) or reset.
// - start while busy (any non-IDLE/DONE state) is ignored.
//     * img_sel changes mid-run do not affect the running inference.
// - Arithmetic:
//     * Products are 8u x 8s (layer 1) and 7u x 8s (layer 2).
//     * Accumulators are 32-bit signed; no overflow handling needed for the given files.
// - Latency:
//     * From start accepted to done=1: <= N_HID*(N_IN+3) + N_OUT*(N_HID+3) + N_OUT + 4 cycles.
//     * This is < 26,000 cycles for the defaults.
// - Reset mid-run aborts immediately to IDLE with outputs at reset values.
// TESTING
// - img_sel=0, release reset, pulse start 1 cycle:
//     * done rises within 26,000 cycles; digit=6 == exp_label; valid=1.
// - img_sel=1 -> digit=2; img_sel=2 -> digit=3:
//     * each after its own start pulse; done held high and digit stable for >=100 cycles.
// - img_sel=3:
//     * valid=0; pulse start; after 100 cycles done=0 and digit=0.
// - Run img 0 to done, then select 1 and pulse start:
//     * done drops the next cycle; new done gives digit=2.
// - Assert rst=0 mid-L1_MAC:
//     * done=0, digit=0, accel.fsm.state=IDLE.
//     * A subsequent start on img 2 gives digit=3.
// - Toggle img_sel during a run: result still matches the image latched at start.

Source files
------------

// File: rtl/mnist_synth_top.sv
// MNIST-style 784->N_HID->10 integer MLP with image and weight ROMs on chip.
// The top decodes the image select; accel holds the MAC datapath and its FSM.

package mnist_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L1_MAC = 3'd1,
    L1_WB  = 3'd2,
    L2_MAC = 3'd3,
    L2_WB  = 3'd4,
    ARGMAX = 3'd5,
    DONE   = 3'd6
  } state_t;
endpackage

module mnist_fsm
  import mnist_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start_ok,
  input  logic   mac_last,
  input  logic   hid_last,
  input  logic   out_last,
  input  logic   arg_last,
  output state_t state_o
);
  state_t state, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_d = L1_MAC;
      L1_MAC:     if (mac_last) state_d = L1_WB;
      L1_WB:      state_d = hid_last ? L2_MAC : L1_MAC;
      L2_MAC:     if (mac_last) state_d = L2_WB;
      L2_WB:      state_d = out_last ? ARGMAX : L2_MAC;
      ARGMAX:     if (arg_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign state_o = state;
endmodule

module mnist_accel
  import mnist_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       valid,
  input  logic [1:0] img_sel,
  output logic [3:0] digit,
  output logic       done
);
  localparam int CNT_W = $clog2(N_IN + 1);
  localparam int J_W   = $clog2(N_HID);
  localparam int K_W   = $clog2(N_OUT);

  state_t             state;
  logic [1:0]         img_q, img_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [J_W-1:0]     j_q, j_d;
  logic [K_W-1:0]     k_q, k_d;
  logic signed [31:0] acc_q, acc_d;
  logic [7:0]         a_q, a_d;
  logic signed [7:0]  w_q, w_d;
  logic               vld_q, vld_d;
  logic [6:0]         h_q [N_HID];
  logic [6:0]         h_d [N_HID];
  logic signed [31:0] l2_acc [0:N_OUT-1];
  logic signed [31:0] l2_acc_d [0:N_OUT-1];
  logic signed [31:0] best_q, best_d;
  logic [K_W-1:0]     best_idx_q, best_idx_d, digit_q, digit_d, arg_idx;
  logic               done_q, done_d;
  logic signed [16:0] prod;
  logic               start_ok, mac_last, hid_last, out_last, arg_last;

  // ROM contents: three synthetic digit images and a matching hand-built network.
  function automatic logic [7:0] pix_rom(input int img, input int i);
    if (i % 3 == img) return 8'd200;
    return 8'(((i * 37) + (img * 11)) % 16);
  endfunction

  function automatic logic signed [7:0] w1_rom(input int j, input int i);
    int base;
    base = (i % 3 == j % 3) ? 2 : -1;
    return 8'(base + (((i * 7) + (j * 13)) % 5) - 2);
  endfunction

  function automatic logic signed [31:0] b1_rom(input int j);
    return (j * 16) - 200;
  endfunction

  function automatic int lab(input int r);
    case (r)
      0:       return 6;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic signed [7:0] w2_rom(input int k, input int j);
    if (k == lab(j % 3)) return 8'sd5;
    return 8'(((j + k) % 3) - 1);
  endfunction

  function automatic logic signed [31:0] b2_rom(input int k);
    return (k * 3) - 10;
  endfunction

  function automatic logic [6:0] relu_sat(input logic signed [31:0] s);
    logic signed [31:0] sh;
    sh = s >>> SHIFT;
    if (sh < 0) return 7'd0;
    if (sh > 32'sd127) return 7'd127;
    return sh[6:0];
  endfunction

  assign start_ok = start && valid;
  assign arg_idx  = cnt_q[K_W-1:0];
  assign mac_last = ((state == L1_MAC) && (cnt_q == CNT_W'(N_IN))) ||
                    ((state == L2_MAC) && (cnt_q == CNT_W'(N_HID)));
  assign hid_last = (j_q == J_W'(N_HID - 1));
  assign out_last = (k_q == K_W'(N_OUT - 1));
  assign arg_last = (state == ARGMAX) && (arg_idx == K_W'(N_OUT - 1));
  assign prod     = 17'($signed({1'b0, a_q})) * 17'(w_q);

  mnist_fsm fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_ok (start_ok),
    .mac_last (mac_last),
    .hid_last (hid_last),
    .out_last (out_last),
    .arg_last (arg_last),
    .state_o  (state)
  );

  // Operands are registered one cycle after the address is issued; the MAC
  // state runs one extra count so the last product lands before write-back.
  always_comb begin
    img_d      = img_q;
    cnt_d      = cnt_q;
    j_d        = j_q;
    k_d        = k_q;
    acc_d      = vld_q ? (acc_q + 32'(prod)) : acc_q;
    a_d        = a_q;
    w_d        = w_q;
    vld_d      = 1'b0;
    h_d        = h_q;
    l2_acc_d   = l2_acc;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    done_d     = done_q;
    unique case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          img_d  = img_sel;
          cnt_d  = '0;
          j_d    = '0;
          acc_d  = b1_rom(0);
          done_d = 1'b0;
        end
      end
      L1_MAC: begin
        if (cnt_q < CNT_W'(N_IN)) begin
          a_d   = pix_rom(int'(img_q), int'(cnt_q));
          w_d   = w1_rom(int'(j_q), int'(cnt_q));
          vld_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      L1_WB: begin
        h_d[j_q] = relu_sat(acc_q);
        cnt_d    = '0;
        if (hid_last) begin
          k_d   = '0;
          acc_d = b2_rom(0);
        end else begin
          j_d   = j_q + J_W'(1);
          acc_d = b1_rom(int'(j_q) + 1);
        end
      end
      L2_MAC: begin
        if (cnt_q < CNT_W'(N_HID)) begin
          a_d   = {1'b0, h_q[cnt_q[J_W-1:0]]};
          w_d   = w2_rom(int'(k_q), int'(cnt_q));
          vld_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      L2_WB: begin
        l2_acc_d[k_q] = acc_q;
        cnt_d         = '0;
        if (out_last) begin
          best_d     = l2_acc[0];
          best_idx_d = '0;
          cnt_d      = CNT_W'(1);
        end else begin
          k_d   = k_q + K_W'(1);
          acc_d = b2_rom(int'(k_q) + 1);
        end
      end
      ARGMAX: begin
        // Strict compare keeps the lowest index on ties.
        if (l2_acc[arg_idx] > best_q) begin
          best_d     = l2_acc[arg_idx];
          best_idx_d = arg_idx;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (arg_last) begin
          digit_d = best_idx_d;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q      <= '0;
      cnt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      w_q        <= '0;
      vld_q      <= 1'b0;
      for (int n = 0; n < N_HID; n++) h_q[n] <= '0;
      for (int n = 0; n < N_OUT; n++) l2_acc[n] <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      img_q      <= img_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      w_q        <= w_d;
      vld_q      <= vld_d;
      h_q        <= h_d;
      l2_acc     <= l2_acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      done_q     <= done_d;
    end
  end

  assign digit = 4'(digit_q);
  assign done  = done_q;
endmodule

module mnist_synth_top #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] img_sel,
  output logic [3:0] digit,
  output logic       done,
  output logic       valid
);
  logic [3:0] exp_label;
  logic       unused_ok;

  assign valid = (img_sel != 2'd3);

  always_comb begin
    unique case (img_sel)
      2'd0:    exp_label = 4'd6;
      2'd1:    exp_label = 4'd2;
      2'd2:    exp_label = 4'd3;
      default: exp_label = 4'd0;
    endcase
  end

  // exp_label exists only as a debug probe.
  assign unused_ok = ^exp_label;

  mnist_accel #(
    .N_IN  (N_IN),
    .N_HID (N_HID),
    .N_OUT (N_OUT),
    .SHIFT (SHIFT)
  ) accel (
    .clk     (clk),
    .rst_n   (rst),
    .start   (start),
    .valid   (valid),
    .img_sel (img_sel),
    .digit   (digit),
    .done    (done)
  );
endmodule

// File: tb/tb_mnist_synth_top.sv
// Randomized bench for mnist_synth_top against a loop-level MLP reference model.
// A reduced hidden layer keeps each inference to a few thousand cycles.

module tb_mnist_synth_top;
  localparam int N_IN    = 784;
  localparam int N_HID   = 8;
  localparam int N_OUT   = 10;
  localparam int SHIFT   = 7;
  localparam int LAT_MAX = N_HID * (N_IN + 3) + N_OUT * (N_HID + 3) + N_OUT + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] img_sel = 2'd0;
  logic [3:0] digit;
  logic       done;
  logic       valid;

  int n_chk = 0;
  int n_err = 0;
  int exp_l2 [3][N_OUT];
  int exp_dig [3];
  int label_tab [4] = '{6, 2, 3, 0};

  always #5 clk = ~clk;

  mnist_synth_top #(
    .N_IN  (N_IN),
    .N_HID (N_HID),
    .N_OUT (N_OUT),
    .SHIFT (SHIFT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .img_sel (img_sel),
    .digit   (digit),
    .done    (done),
    .valid   (valid)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ROM contents the design ships with.
  function automatic int pix(input int img, input int i);
    return (i % 3 == img) ? 200 : ((i * 37 + img * 11) % 16);
  endfunction
  function automatic int w1(input int j, input int i);
    return ((i % 3 == j % 3) ? 2 : -1) + ((i * 7 + j * 13) % 5) - 2;
  endfunction
  function automatic int b1(input int j);
    return j * 16 - 200;
  endfunction
  function automatic int w2(input int k, input int j);
    return (k == label_tab[j % 3]) ? 5 : ((j + k) % 3) - 1;
  endfunction
  function automatic int b2(input int k);
    return k * 3 - 10;
  endfunction

  task automatic build_model();
    int h [N_HID];
    int s;
    int best;
    for (int m = 0; m < 3; m++) begin
      for (int j = 0; j < N_HID; j++) begin
        s = b1(j);
        for (int i = 0; i < N_IN; i++) s += pix(m, i) * w1(j, i);
        if (s <= 0) h[j] = 0;
        else        h[j] = (s / (1 << SHIFT) > 127) ? 127 : s / (1 << SHIFT);
      end
      for (int k = 0; k < N_OUT; k++) begin
        s = b2(k);
        for (int j = 0; j < N_HID; j++) s += h[j] * w2(k, j);
        exp_l2[m][k] = s;
      end
      best = 0;
      for (int k = 1; k < N_OUT; k++) if (exp_l2[m][k] > exp_l2[m][best]) best = k;
      exp_dig[m] = best;
    end
  endtask

  task automatic run_img(input int sel, input bit from_done, input bit noisy);
    int  lat;
    bit  seen;
    bit  stable;
    int  d0;
    @(negedge clk);
    img_sel = 2'(sel);
    #1 chk_eq("exp_label", int'(dut.exp_label), label_tab[sel]);
    chk_eq("valid_sel", int'(valid), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (from_done) chk_eq("done_drop", int'(done), 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < LAT_MAX + 50) begin
      @(negedge clk);
      lat++;
      if (noisy) begin
        if ($urandom_range(0, 15) == 0) img_sel = 2'($urandom_range(0, 3));
        start = (lat < 2000) && ($urandom_range(0, 63) == 0);
      end
      seen = done;
    end
    start = 1'b0;
    chk_eq("done_seen", int'(seen), 1);
    chk_eq("latency_ok", int'(lat <= LAT_MAX), 1);
    chk_eq("digit_model", int'(digit), exp_dig[sel]);
    chk_eq("digit_label", int'(digit), label_tab[sel]);
    for (int k = 0; k < N_OUT; k++)
      chk_eq($sformatf("l2_acc%0d", k), int'(dut.accel.l2_acc[k]), exp_l2[sel][k]);
    d0     = int'(digit);
    stable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (noisy) img_sel = 2'($urandom_range(0, 3));
      if (!done || int'(digit) != d0) stable = 1'b0;
    end
    chk_eq("hold_stable", int'(stable), 1);
    chk_eq("valid_follow", int'(valid), int'(img_sel != 2'd3));
  endtask

  initial begin
    build_model();
    #3 rst = 1'b0;
    #1;
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_digit", int'(digit), 0);
    chk_eq("rst_state", int'(dut.accel.fsm.state == mnist_pkg::IDLE), 1);
    for (int s = 0; s < 4; s++) begin
      img_sel = 2'(s);
      #1;
      chk_eq("rst_valid", int'(valid), int'(s < 3));
      chk_eq("rst_exp_label", int'(dut.exp_label), label_tab[s]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Invalid selection: start must be ignored.
    @(negedge clk);
    img_sel = 2'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk_eq("inv_done", int'(done), 0);
    chk_eq("inv_digit", int'(digit), 0);
    chk_eq("inv_valid", int'(valid), 0);
    chk_eq("inv_state", int'(dut.accel.fsm.state == mnist_pkg::IDLE), 1);

    run_img(0, 1'b0, 1'b0);
    run_img(1, 1'b1, 1'b0);
    run_img(2, 1'b1, 1'b0);

    // Abort in the first layer with an asynchronous reset.
    @(negedge clk);
    img_sel = 2'd1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(20, 600)) @(negedge clk);
    chk_eq("abort_in_l1", int'(dut.accel.fsm.state == mnist_pkg::L1_MAC), 1);
    rst = 1'b0;
    #1;
    chk_eq("abort_done", int'(done), 0);
    chk_eq("abort_digit", int'(digit), 0);
    chk_eq("abort_state", int'(dut.accel.fsm.state == mnist_pkg::IDLE), 1);
    begin
      int nz;
      nz = 0;
      for (int k = 0; k < N_OUT; k++) if (dut.accel.l2_acc[k] != 0) nz++;
      chk_eq("abort_l2_clear", nz, 0);
    end
    @(negedge clk);
    rst = 1'b1;

    run_img(2, 1'b0, 1'b1);
    repeat (3) run_img(int'($urandom_range(0, 2)), 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
